// File: rtl/flash_cmd_seq_pkg.sv
// flash_cmd_seq_pkg: op encodings, flash command bytes, status bits and FSM states
package flash_cmd_seq_pkg;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_PROGRAM = 2'd1, OP_ERASE = 2'd2, OP_STATUS = 2'd3} op_e;
  typedef enum logic [2:0] {IDLE, CMD1, CMD2, RDATA, POLL, CLRSR, RDARR, RESP} state_e;
  localparam logic [7:0] FC_READ_ARRAY = 8'hFF;
  localparam logic [7:0] FC_PROGRAM    = 8'h40;
  localparam logic [7:0] FC_ERASE      = 8'h20;
  localparam logic [7:0] FC_CONFIRM    = 8'hD0;
  localparam logic [7:0] FC_READ_SR    = 8'h70;
  localparam logic [7:0] FC_CLEAR_SR   = 8'h50;
  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPP_ERR   = 3;
  localparam int SR_LOCK_ERR  = 1;
  function automatic logic sr_error(input logic [7:0] sr);
    return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
  endfunction
  function automatic logic [7:0] cmd1_byte(input op_e op);
    return op == OP_READ ? FC_READ_ARRAY : op == OP_PROGRAM ? FC_PROGRAM :
           op == OP_ERASE ? FC_ERASE : FC_READ_SR;
  endfunction
endpackage

// File: rtl/flash_bus_if.sv
// flash_bus_if: holds one strobe until fb_stall drops, then forces a single idle cycle
module flash_bus_if (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [21:0] addr,
  input  logic [15:0] wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic [23:0] fb_address,
  output logic [31:0] fb_data_o,
  output logic        fb_read,
  output logic        fb_write,
  input  logic [31:0] fb_data_i,
  input  logic        fb_stall
);
  logic unused_hi;
  assign unused_hi = ^fb_data_i[31:16];
  assign done = (fb_read | fb_write) & ~fb_stall;
  assign rdata = fb_data_i[15:0];
  // a new access only launches from a low-strobe cycle, which is the gap
  always_ff @(posedge clk_bus or negedge rst_n)
    if (!rst_n) begin
      fb_read <= 1'b0;
      fb_write <= 1'b0;
      fb_address <= '0;
      fb_data_o <= '0;
    end else if (done) begin
      fb_read <= 1'b0;
      fb_write <= 1'b0;
    end else if (!fb_read && !fb_write && req) begin
      fb_read <= ~we;
      fb_write <= we;
      fb_address <= {addr, 2'b00};
      fb_data_o <= {16'h0, wdata};
    end
endmodule

// File: rtl/flash_cmd_seq.sv
// flash_cmd_seq: sequences READ/PROGRAM/ERASE/STATUS commands onto a stalling flash bus
module flash_cmd_seq
  import flash_cmd_seq_pkg::*;
#(
  parameter logic [15:0] POLL_LIMIT = 16'd50000
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [21:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [7:0]  rsp_status,
  output logic        rsp_error,
  output logic [23:0] fb_address,
  output logic [31:0] fb_data_o,
  input  logic [31:0] fb_data_i,
  output logic        fb_read,
  output logic        fb_write,
  input  logic        fb_stall
);
  state_e state;
  op_e op;
  logic [21:0] addr;
  logic [15:0] wdata_r, data_r, poll_cnt, poll_nxt, bus_wdata, rdata;
  logic [7:0] stat_r;
  logic err_r, req, we, done;
  always_comb begin
    req = state != IDLE && state != RESP;
    we = state == CMD1 || state == CMD2 || state == CLRSR || state == RDARR;
    bus_wdata = state == CMD1 ? {8'h00, cmd1_byte(op)} :
                state == CMD2 ? (op == OP_PROGRAM ? wdata_r : {8'h00, FC_CONFIRM}) :
                {8'h00, state == CLRSR ? FC_CLEAR_SR : FC_READ_ARRAY};
    poll_nxt = poll_cnt == 16'hFFFF ? poll_cnt : poll_cnt + 16'd1;
  end
  flash_bus_if u_bus (
    .clk_bus(clk_bus), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(bus_wdata),
    .done(done), .rdata(rdata), .fb_address(fb_address), .fb_data_o(fb_data_o),
    .fb_read(fb_read), .fb_write(fb_write), .fb_data_i(fb_data_i), .fb_stall(fb_stall)
  );
  always_ff @(posedge clk_bus or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      op <= OP_READ;
      addr <= '0;
      wdata_r <= '0;
      data_r <= '0;
      stat_r <= '0;
      err_r <= 1'b0;
      poll_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_status <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          state <= CMD1;
          cmd_ready <= 1'b0;
          op <= op_e'(cmd_op);
          addr <= cmd_addr;
          wdata_r <= cmd_wdata;
          data_r <= '0;
          err_r <= 1'b0;
          poll_cnt <= '0;
        end else cmd_ready <= 1'b1;
        CMD1: if (done) state <= (op == OP_READ || op == OP_STATUS) ? RDATA : CMD2;
        CMD2: if (done) state <= POLL;
        RDATA: if (done) begin
          data_r <= op == OP_STATUS ? {8'h00, rdata[7:0]} : rdata;
          state <= op == OP_STATUS ? RDARR : RESP;
        end
        POLL: if (done) begin
          poll_cnt <= poll_nxt;
          stat_r <= rdata[7:0];
          // ready wins over timeout when both land on the same poll
          if (rdata[SR_READY]) begin
            err_r <= sr_error(rdata[7:0]);
            state <= sr_error(rdata[7:0]) ? CLRSR : RDARR;
          end else if (poll_nxt >= POLL_LIMIT) begin
            err_r <= 1'b1;
            state <= CLRSR;
          end
        end
        CLRSR: if (done) state <= RDARR;
        RDARR: if (done) state <= RESP;
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_data <= data_r;
          rsp_status <= stat_r;
          rsp_error <= err_r;
          cmd_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_flash_cmd_seq.sv
// tb_flash_cmd_seq: scoreboard bench with a stalling flash model and directed commands
module tb_flash_cmd_seq;
  import flash_cmd_seq_pkg::*;
  typedef struct {logic we; logic [23:0] addr; logic [15:0] data;} acc_t;
  typedef struct {logic [15:0] data; logic [7:0] st; logic err;} rsp_t;
  logic clk_bus = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [21:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_error, fb_read, fb_write, fb_stall;
  logic [15:0] rsp_data;
  logic [7:0] rsp_status;
  logic [23:0] fb_address;
  logic [31:0] fb_data_o, fb_data_i;
  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  logic [15:0] rd_q[$];
  logic [15:0] cur_rd;
  int stall_cfg = 0, cnt, n_cmp = 0, n_bad = 0;

  flash_cmd_seq #(.POLL_LIMIT(16'd4)) dut (
    .clk_bus(clk_bus), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_error(rsp_error),
    .fb_address(fb_address), .fb_data_o(fb_data_o), .fb_data_i(fb_data_i),
    .fb_read(fb_read), .fb_write(fb_write), .fb_stall(fb_stall)
  );

  always #5 clk_bus = ~clk_bus;

  assign fb_stall = (fb_read | fb_write) && (cnt < stall_cfg);
  assign fb_data_i = {16'h0, cur_rd};

  always @(posedge clk_bus or negedge rst_n)
    if (!rst_n) begin
      cnt <= 0;
      cur_rd <= 16'h0;
    end else begin
      cnt <= ((fb_read | fb_write) && fb_stall) ? cnt + 1 : 0;
      if (fb_read && !fb_stall && rd_q.size() > 0) void'(rd_q.pop_front());
      cur_rd <= rd_q.size() > 0 ? rd_q[0] : 16'h0;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic ew(input logic [23:0] a, input logic [15:0] d);
    exp_acc.push_back('{1'b1, a, d});
  endtask

  task automatic er(input logic [23:0] a);
    exp_acc.push_back('{1'b0, a, 16'h0});
  endtask

  logic prev_strb = 1'b0, prev_stall = 1'b0, armed = 1'b0, snap_rw;
  logic [23:0] snap_addr;
  logic [31:0] snap_data;
  int gap = 0;
  acc_t ea;
  rsp_t rsp_e;

  always @(negedge clk_bus)
    if (!rst_n) begin
      prev_strb = 1'b0;
      prev_stall = 1'b0;
      armed = 1'b0;
      gap = 0;
    end else begin
      if (fb_read | fb_write) chk("rw_exclusive", 32'(fb_read & fb_write), 32'd0);
      if (prev_stall) begin
        chk("stall_strobe", 32'({fb_read, fb_write}), 32'({~snap_rw, snap_rw}));
        chk("stall_addr", 32'(fb_address), 32'(snap_addr));
        chk("stall_data", fb_data_o, snap_data);
      end
      if ((fb_read | fb_write) && !prev_strb && armed) chk("gap_cycles", 32'(gap), 32'd1);
      if (!(fb_read | fb_write)) gap++;
      if ((fb_read | fb_write) && !fb_stall) begin
        if (exp_acc.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL acc_unexpected: got we=%0b @%h expected none", fb_write, fb_address);
        end else begin
          ea = exp_acc.pop_front();
          chk("acc_we", 32'(fb_write), 32'(ea.we));
          chk("acc_addr", 32'(fb_address), 32'(ea.addr));
          if (ea.we) chk("acc_wdata", fb_data_o, {16'h0, ea.data});
        end
        armed = 1'b1;
        gap = 0;
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got data=%h expected none", rsp_data);
        end else begin
          rsp_e = exp_rsp.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(rsp_e.data));
          chk("rsp_status", 32'(rsp_status), 32'(rsp_e.st));
          chk("rsp_error", 32'(rsp_error), 32'(rsp_e.err));
        end
        armed = 1'b0;
      end
      prev_strb = fb_read | fb_write;
      prev_stall = prev_strb && fb_stall;
      snap_rw = fb_write;
      snap_addr = fb_address;
      snap_data = fb_data_o;
    end

  task automatic issue(input op_e op, input logic [21:0] a, input logic [15:0] d);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk_bus);
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = d;
    @(negedge clk_bus);
    cmd_valid = 1'b0;
  endtask

  task automatic run(input op_e op, input logic [21:0] a, input logic [15:0] d, input bit pulse);
    int n = 0;
    issue(op, a, d);
    while (!rsp_valid && n < 400) begin
      if (pulse) begin
        chk("ready_busy", 32'(cmd_ready), 32'd0);
        cmd_valid = (n == 4);
        cmd_op = OP_READ;
      end
      @(negedge clk_bus);
      n++;
    end
    cmd_valid = 1'b0;
    chk("rsp_arrived", 32'(rsp_valid), 32'd1);
    @(negedge clk_bus);
    chk("acc_left", 32'(exp_acc.size()), 32'd0);
    chk("rsp_left", 32'(exp_rsp.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk_bus);
    chk("rst_fb_read", 32'(fb_read), 32'd0);
    chk("rst_fb_write", 32'(fb_write), 32'd0);
    chk("rst_fb_address", 32'(fb_address), 32'd0);
    chk("rst_fb_data_o", fb_data_o, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk_bus);
    #1 chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    @(negedge clk_bus);
    // READ
    rd_q.push_back(16'hBEEF);
    ew(24'h000400, 16'h00FF);
    er(24'h000400);
    exp_rsp.push_back('{16'hBEEF, 8'h00, 1'b0});
    run(OP_READ, 22'h000100, 16'h0, 1'b0);
    // PROGRAM, ready on third poll
    rd_q.push_back(16'h0000);
    rd_q.push_back(16'h0000);
    rd_q.push_back(16'h0080);
    ew(24'hFFFFFC, 16'h0040);
    ew(24'hFFFFFC, 16'h1234);
    repeat (3) er(24'hFFFFFC);
    ew(24'hFFFFFC, 16'h00FF);
    exp_rsp.push_back('{16'h0000, 8'h80, 1'b0});
    run(OP_PROGRAM, 22'h3FFFFF, 16'h1234, 1'b0);
    // ERASE with erase-error status
    rd_q.push_back(16'h00A0);
    ew(24'h000040, 16'h0020);
    ew(24'h000040, 16'h00D0);
    er(24'h000040);
    ew(24'h000040, 16'h0050);
    ew(24'h000040, 16'h00FF);
    exp_rsp.push_back('{16'h0000, 8'hA0, 1'b1});
    run(OP_ERASE, 22'h000010, 16'h0, 1'b0);
    // PROGRAM timeout, status stuck at 00
    ew(24'h000020, 16'h0040);
    ew(24'h000020, 16'hABCD);
    repeat (4) er(24'h000020);
    ew(24'h000020, 16'h0050);
    ew(24'h000020, 16'h00FF);
    exp_rsp.push_back('{16'h0000, 8'h00, 1'b1});
    run(OP_PROGRAM, 22'h000008, 16'hABCD, 1'b0);
    // STATUS with 3-cycle stalls and a cmd_valid pulse while busy
    stall_cfg = 3;
    rd_q.push_back(16'h0080);
    ew(24'h000800, 16'h0070);
    er(24'h000800);
    ew(24'h000800, 16'h00FF);
    exp_rsp.push_back('{16'h0080, 8'h00, 1'b0});
    run(OP_STATUS, 22'h000200, 16'h0, 1'b1);
    // reset while a poll read is stalled
    ew(24'h000080, 16'h0040);
    ew(24'h000080, 16'h5555);
    issue(OP_PROGRAM, 22'h000020, 16'h5555);
    n = 0;
    while (!fb_read && n < 100) begin
      @(negedge clk_bus);
      n++;
    end
    chk("poll_seen", 32'(fb_read), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("abort_fb_read", 32'(fb_read), 32'd0);
    chk("abort_fb_write", 32'(fb_write), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_acc_left", 32'(exp_acc.size()), 32'd0);
    rd_q.delete();
    stall_cfg = 0;
    repeat (2) @(negedge clk_bus);
    rst_n = 1'b1;
    // STATUS after the aborted command
    rd_q.push_back(16'h0080);
    ew(24'h000010, 16'h0070);
    er(24'h000010);
    ew(24'h000010, 16'h00FF);
    exp_rsp.push_back('{16'h0080, 8'h00, 1'b0});
    run(OP_STATUS, 22'h000004, 16'h0, 1'b0);
    repeat (3) @(negedge clk_bus);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
